// File: rtl/pipe_reg_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain_pkg
// Description : Shared constants and helpers for the elastic register
//               pipeline and other streaming blocks that use the same
//               {valid, data} beat layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_reg_chain_pkg;

    // Largest supported chain depth; deeper requests are clamped.
    localparam int PIPE_MAX_DEPTH = 16;

    // Beat layout: valid flag sits directly above the data field.
    localparam int BEAT_VALID_OFS = 0;   // offset above the data MSB
    localparam int BEAT_DATA_LSB  = 0;

    // Ceiling log2, usable in constant expressions.
    function automatic int pipe_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : pipe_reg_chain_pkg
`default_nettype wire

// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain_if
// Description : valid/ready/data streaming handshake.
//               master : drives valid + data, receives ready
//               slave  : receives valid + data, drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_chain_if
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface : pipe_reg_chain_if
`default_nettype wire

// File: rtl/pipe_reg_chain_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain_stage
// Description : One stage of the elastic pipeline: valid + data registers and
//               the combinational advance term for the ready chain.
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   flush_i    in   clear valid (only with PIPE_FLUSH_EN defined)
//   v_i/d_i    in   beat offered by the previous stage (or upstream)
//   adv_next_i in   advance of the following stage (or downstream ready)
//   v_o/d_o    out  beat held by this stage
//   adv_o      out  this stage loads on the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
`ifdef PIPE_FLUSH_EN
    input  wire logic             flush_i,
`endif
    input  wire logic             v_i,
    input  wire logic [WIDTH-1:0] d_i,
    input  wire logic             adv_next_i,
    output logic                  v_o,
    output logic [WIDTH-1:0]      d_o,
    output logic                  adv_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // An empty stage can always take a beat, which is what collapses bubbles.
    assign adv_o = ~v_q | adv_next_i;
    assign v_o   = v_q;
    assign d_o   = d_q;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (adv_o) begin
            v_d = v_i;
            // Bubbles leave the data register untouched.
            if (v_i) begin
                d_d = d_i;
            end
        end
`ifdef PIPE_FLUSH_EN
        // Flush wins over the same-cycle load; data keeps its old value.
        if (flush_i) begin
            v_d = 1'b0;
            d_d = d_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule : pipe_reg_chain_stage
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : Elastic register pipeline of DEPTH stages with valid/ready
//               back-pressure and bubble collapse. Zero-stall latency is
//               DEPTH cycles, throughput one beat per cycle.
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   flush  in   clears all stage valids (present only with PIPE_FLUSH_EN)
//   up     slave  upstream beats (in_valid / in_ready / in_data)
//   dn     master downstream beats (out_valid / out_ready / out_data)
// Optional feature macro: PIPE_FLUSH_EN
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
`ifdef PIPE_FLUSH_EN
    input  wire logic        flush,
`endif
    pipe_reg_chain_if.slave  up,
    pipe_reg_chain_if.master dn
);

    // Depth clamped to the supported range.
    localparam int c_depth = (DEPTH < 1) ? 1 :
                             (DEPTH > PIPE_MAX_DEPTH) ? PIPE_MAX_DEPTH : DEPTH;

    logic             w_vin  [c_depth];
    logic [WIDTH-1:0] w_din  [c_depth];
    logic             w_v    [c_depth];
    logic [WIDTH-1:0] w_d    [c_depth];
    logic             w_adv  [c_depth+1];

    // Ready chain closes on the downstream ready; in_ready never sees in_valid.
    assign w_adv[c_depth] = dn.ready;
    assign up.ready       = w_adv[0];
    assign dn.valid       = w_v[c_depth-1];
    assign dn.data        = w_d[c_depth-1];

    for (genvar i = 0; i < c_depth; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_vin[i] = up.valid;
            assign w_din[i] = up.data;
        end else begin : g_body
            assign w_vin[i] = w_v[i-1];
            assign w_din[i] = w_d[i-1];
        end

        pipe_reg_chain_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
`ifdef PIPE_FLUSH_EN
            .flush_i    (flush),
`endif
            .v_i        (w_vin[i]),
            .d_i        (w_din[i]),
            .adv_next_i (w_adv[i+1]),
            .v_o        (w_v[i]),
            .d_o        (w_d[i]),
            .adv_o      (w_adv[i])
        );
    end

endmodule : pipe_reg_chain
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_chain
// Description : Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=4).
//               Accepted input beats go into a queue; every output transfer
//               pops and compares. Inputs change 1 time unit after posedge,
//               outputs are sampled on negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
`ifdef PIPE_FLUSH_EN
    logic flush;
`endif

    pipe_reg_chain_if #(.WIDTH(WIDTH)) up_if ();
    pipe_reg_chain_if #(.WIDTH(WIDTH)) dn_if ();

    pipe_reg_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef PIPE_FLUSH_EN
        .flush (flush),
`endif
        .up    (up_if),
        .dn    (dn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] sb[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n       = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 8'h77;
        dn_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        up_if.valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dn_if.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", dn_if.valid);
        end
        n_checks++;
        if (dn_if.data !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_data: got %h want 00", dn_if.data);
        end
        n_checks++;
        if (up_if.ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", up_if.ready);
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_streaming();
        int p;
        logic exp_v;
        logic [WIDTH-1:0] e;
        p = 0;
        dn_if.ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            up_if.valid = (p < 8);
            up_if.data  = 8'(p + 1);
            @(negedge clk);
            if (p < 8) begin
                n_checks++;
                if (up_if.ready !== 1'b1) begin
                    n_fail++; $display("FAIL stream_in_ready c%0d: got %b want 1", k, up_if.ready);
                end
            end
            exp_v = (k >= DEPTH) && (k < DEPTH + 8);
            n_checks++;
            if (dn_if.valid !== exp_v) begin
                n_fail++; $display("FAIL stream_out_valid c%0d: got %b want %b", k, dn_if.valid, exp_v);
            end
            if (dn_if.valid === 1'b1 && dn_if.ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra_beat: got %h want none", dn_if.data);
                end else begin
                    e = sb.pop_front();
                    if (dn_if.data !== e) begin
                        n_fail++; $display("FAIL stream_data: got %h want %h", dn_if.data, e);
                    end
                end
            end
            if (up_if.valid && up_if.ready === 1'b1) begin
                sb.push_back(up_if.data);
                p++;
            end
            @(posedge clk); #1;
        end
        up_if.valid = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL stream_left: got %0d beats want 0", sb.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall_fill();
        int p;
        logic exp_r;
        logic [WIDTH-1:0] e;
        p = 0;
        sb.delete();
        dn_if.ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            up_if.valid = 1'b1;
            up_if.data  = 8'hA0 + 8'(p);
            @(negedge clk);
            exp_r = (p < DEPTH);
            n_checks++;
            if (up_if.ready !== exp_r) begin
                n_fail++; $display("FAIL stall_in_ready c%0d: got %b want %b", k, up_if.ready, exp_r);
            end
            if (dn_if.valid === 1'b1 && sb.size() > 0) begin
                n_checks++;
                if (dn_if.data !== sb[0]) begin
                    n_fail++; $display("FAIL stall_hold_data c%0d: got %h want %h", k, dn_if.data, sb[0]);
                end
            end
            if (up_if.ready === 1'b1) begin
                sb.push_back(up_if.data);
                p++;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (p != DEPTH) begin
            n_fail++; $display("FAIL stall_accepted: got %0d want %0d", p, DEPTH);
        end
        dn_if.ready = 1'b1;
        for (int k = 0; k < 20 && (p < 6 || sb.size() > 0); k++) begin
            up_if.valid = (p < 6);
            up_if.data  = 8'hA0 + 8'(p);
            @(negedge clk);
            if (dn_if.valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra_beat: got %h want none", dn_if.data);
                end else begin
                    e = sb.pop_front();
                    if (dn_if.data !== e) begin
                        n_fail++; $display("FAIL stall_data: got %h want %h", dn_if.data, e);
                    end
                end
            end
            if (up_if.valid && up_if.ready === 1'b1) begin
                sb.push_back(up_if.data);
                p++;
            end
            @(posedge clk); #1;
        end
        up_if.valid = 1'b0;
        n_checks++;
        if (sb.size() != 0 || p != 6) begin
            n_fail++; $display("FAIL stall_drain: got %0d left %0d sent want 0 left 6 sent", sb.size(), p);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_pop_push();
        logic [WIDTH-1:0] e;
        sb.delete();
        dn_if.ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            up_if.valid = 1'b1;
            up_if.data  = 8'hB0 + 8'(k);
            @(negedge clk);
            if (up_if.ready === 1'b1) sb.push_back(up_if.data);
            @(posedge clk); #1;
        end
        // Full chain: simultaneous pop and push.
        up_if.valid = 1'b1;
        up_if.data  = 8'hB4;
        dn_if.ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (up_if.ready !== 1'b1) begin
            n_fail++; $display("FAIL full_popush_in_ready: got %b want 1", up_if.ready);
        end
        n_checks++;
        if (dn_if.valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL full_popush_out_valid: got %b want 1", dn_if.valid);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (dn_if.data !== e) begin
                n_fail++; $display("FAIL full_popush_data: got %h want %h", dn_if.data, e);
            end
        end
        if (up_if.ready === 1'b1) sb.push_back(up_if.data);
        @(posedge clk); #1;
        // Occupancy must still be DEPTH: nothing more can enter while stalled.
        up_if.valid = 1'b0;
        dn_if.ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (up_if.ready !== 1'b0) begin
            n_fail++; $display("FAIL full_still_full: got in_ready %b want 0", up_if.ready);
        end
        @(posedge clk); #1;
        dn_if.ready = 1'b1;
        for (int k = 0; k < 12 && sb.size() > 0; k++) begin
            @(negedge clk);
            if (dn_if.valid === 1'b1) begin
                e = sb.pop_front();
                n_checks++;
                if (dn_if.data !== e) begin
                    n_fail++; $display("FAIL full_drain_data: got %h want %h", dn_if.data, e);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL full_drain_left: got %0d want 0", sb.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bubbles();
        logic             vpat [4];
        logic [WIDTH-1:0] dpat [4];
        logic             exp_v;
        logic [WIDTH-1:0] e;
        vpat = '{1'b1, 1'b0, 1'b1, 1'b0};
        dpat = '{8'h11, 8'hFF, 8'h22, 8'hFF};
        sb.delete();
        dn_if.ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            up_if.valid = (k < 4) ? vpat[k] : 1'b0;
            up_if.data  = (k < 4) ? dpat[k] : 8'hFF;
            @(negedge clk);
            exp_v = (k >= DEPTH && k < DEPTH + 4) ? vpat[k-DEPTH] : 1'b0;
            n_checks++;
            if (dn_if.valid !== exp_v) begin
                n_fail++; $display("FAIL bubble_out_valid c%0d: got %b want %b", k, dn_if.valid, exp_v);
            end
            if (dn_if.valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (dn_if.data !== e) begin
                    n_fail++; $display("FAIL bubble_data: got %h want %h", dn_if.data, e);
                end
            end
            if (up_if.valid && up_if.ready === 1'b1) sb.push_back(up_if.data);
            @(posedge clk); #1;
        end
        up_if.valid = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL bubble_left: got %0d want 0", sb.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_midrun_reset();
        logic exp_v;
        sb.delete();
        dn_if.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            up_if.valid = 1'b1;
            up_if.data  = 8'hC1 + 8'(k);
            @(posedge clk); #1;
        end
        up_if.valid = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dn_if.valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_out_valid: got %b want 0", dn_if.valid);
        end
        n_checks++;
        if (up_if.ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_in_ready: got %b want 1", up_if.ready);
        end
        n_checks++;
        if (dn_if.data !== 8'h00) begin
            n_fail++; $display("FAIL midreset_out_data: got %h want 00", dn_if.data);
        end
        @(posedge clk); #1;
        dn_if.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            up_if.valid = (k == 0);
            up_if.data  = 8'h5A;
            @(negedge clk);
            exp_v = (k == DEPTH);
            n_checks++;
            if (dn_if.valid !== exp_v) begin
                n_fail++; $display("FAIL midreset_5a_valid c%0d: got %b want %b", k, dn_if.valid, exp_v);
            end
            if (dn_if.valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0 || dn_if.data !== sb[0]) begin
                    n_fail++; $display("FAIL midreset_5a_data: got %h want 5a", dn_if.data);
                end
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (up_if.valid && up_if.ready === 1'b1) sb.push_back(up_if.data);
            @(posedge clk); #1;
        end
        up_if.valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst_n       = 1'b0;
`ifdef PIPE_FLUSH_EN
        flush       = 1'b0;
`endif
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_full_pop_push();
        test_bubbles();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_reg_chain
`default_nettype wire
